matrix_rx: RTL and testbench
============================

Name: matrix_rx

Overview:
- Receive-side counterpart of the 8x8 matrix driver's serial shift/latch interface.
- Deserialises the shift clock / latch / data lines back into an 8-row frame buffer.
- Exposes the frame as a read-only Wishbone slave using the driver's own packed [.RGB.RGB] x4-byte row format.
- Used for on-board loopback (gp pins) and as a bench checker for the driver.

Parameters:
- SHIFT_BITS, 32, bits per latched word: [31:24] one-hot row select, [23:0] pixels 7..0 as RGB triplets, MSB first.
- SYNC_STAGES, 2, synchroniser flops on each serial input (minimum 2).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- i_sclk  input  1  serial shift clock, asynchronous to clk
- i_latch  input  1  output-latch strobe, asynchronous
- i_mosi  input  1  serial data, asynchronous
- i_wb_cyc  input  1  Wishbone cycle
- i_wb_stb  input  1  Wishbone strobe
- i_wb_we  input  1  Wishbone write enable (writes ignored)
- i_wb_addr  input  3  row index 0..7
- i_wb_sel  input  4  byte select (ignored on read; full word returned)
- i_wb_wdata  input  32  unused
- o_wb_ack  output  1  one-cycle acknowledge
- o_wb_stall  output  1  tied 0
- o_wb_rdata  output  32  packed row data
- o_frame_cnt  output  8  count of accepted words, wraps 255->0
- o_err  output  1  one-cycle pulse on a rejected word
- o_err_sticky  output  1  set on any rejection; cleared only by reset

Behaviour:
- Clock and reset: clk and reset_n is one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0; row buffer all 0; shift register 0; bit counter 0; synchronisers 0.
- Input synchronisation:
  - Each of i_sclk, i_latch and i_mosi passes through SYNC_STAGES flops, plus one history flop on sclk and latch.
  - A rising edge is sync==1 && prev==0.
  - Inputs must hold high and low for at least SYNC_STAGES+1 clk periods each.
- Shift: on an sclk rising edge, shreg <= {shreg[SHIFT_BITS-2:0], mosi_sync}. The bit counter increments and saturates at SHIFT_BITS+1.
- Latch rising edge:
  - Evaluates the pre-shift shreg and the bit counter.
  - Accept when the counter == SHIFT_BITS and shreg[31:24] is one-hot.
    - Row r = index of the set bit (bit 24 -> row 0).
    - row_buf[r] <= packed form of shreg[23:0].
    - o_frame_cnt++.
  - Reject (count mismatch, zero select, or multi-hot select): buffer unchanged; o_err=1 for one cycle; o_err_sticky=1.
  - The bit counter resets to 0.
- Simultaneous sclk and latch edge in the same cycle:
  - The latch evaluates the pre-shift value.
  - The shift still happens; the counter becomes 1, so that bit belongs to the next word.
- Packing: pixel p (0..7) uses shreg[3p+2:3p] as {R,G,B}.
  - It lands in byte p/2: bits [3:0] for even p, bits [7:4] for odd p.
  - Bits 3 and 7 of each byte are 0.
- Wishbone:
  - A cycle with cyc&&stb gives o_wb_ack=1 on the next clk.
  - o_wb_rdata is registered in the same cycle as ack: row_buf[addr] as sampled in the request cycle. An update landing in that same cycle returns the old value.
  - Writes are acked with no effect. Back-to-back requests give back-to-back acks.
  - When there is no request, ack=0 and rdata holds its previous value.
- Reset mid-word: discards partial shreg and counter. The next word starts clean.

Decomposition:
- Package matrix_pkg:
  - ROWS=8, PIX_PER_ROW=8, ROW_SEL_LSB=24.
  - Function pack_row(24b)->32b, shared with the driver for its unpack.
  - Function onehot_index(8b)->{valid,3b idx}.
- Sub-module sync_edge (parameter SYNC_STAGES): synchroniser plus rising-edge pulse, instantiated three times (edge output unused for mosi).

Test Plan:
- Shift 32'h01_FFFFFF then latch; read addr 0 -> 32'h77777777, frame_cnt=1, o_err never high.
- Shift 32'h80_000005 (row 7, pixel0=101 RGB) then latch; read addr 7 -> 32'h00000005; other rows remain 0.
- Shift 31 bits then latch -> o_err pulses once, sticky=1, no row changes, frame_cnt unchanged; next valid 32-bit word is accepted.
- Select byte 8'h03 (multi-hot) and 8'h00 -> both rejected, two o_err pulses.
- sclk and latch rising in the same clk after 32 valid bits -> pre-shift word accepted; bit counter=1 after.
- Drop reset_n low mid-word after 16 bits -> outputs and buffer 0 immediately; a following full word is accepted correctly. Wishbone write to addr 2 is acked in 1 cycle and the row is unchanged.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants and helpers for the 8x8 matrix serial link (driver and receiver).
// Latency: n/a (package only; functions are purely combinational).
// Backpressure: n/a.
package matrix_pkg;

    localparam int ROWS        = 8;
    localparam int PIX_PER_ROW = 8;
    localparam int ROW_SEL_LSB = 24;
    localparam int SEL_W       = 8;
    localparam int PIX_W       = 3;

    // Serial pixel field (8 x RGB, pixel 0 in the low bits) to the bus row word.
    // Each pixel owns one nibble: even pixels the low nibble of byte p/2, odd
    // pixels the high nibble. The nibble MSB (bits 3 and 7 of each byte) is 0.
    function automatic logic [31:0] pack_row(input logic [23:0] pix);
        logic [31:0] row;
        row = '0;
        for (int p = 0; p < PIX_PER_ROW; p++) begin
            row[4*p +: PIX_W] = pix[PIX_W*p +: PIX_W];
        end
        return row;
    endfunction

    // Row select decode: {valid, index}. valid only when exactly one bit is set.
    function automatic logic [3:0] onehot_index(input logic [7:0] sel);
        logic [2:0] idx;
        int         n_set;
        idx   = '0;
        n_set = 0;
        for (int i = 0; i < SEL_W; i++) begin
            if (sel[i]) begin
                idx   = 3'(i);
                n_set = n_set + 1;
            end
        end
        return {(n_set == 1), idx};
    endfunction

endpackage

// File: rtl/matrix_rx_sync_edge.sv
// Multi-flop synchroniser for one asynchronous line, plus a rising-edge pulse.
// Latency: SYNC_STAGES clk to o_sync, one more history flop for the edge compare.
// Backpressure: none; the source must hold each level SYNC_STAGES+1 clk periods.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the raw line through the synchroniser chain and keep one history bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/matrix_rx.sv
// Serial shift/latch receiver into an 8-row frame buffer, read back over Wishbone.
// Latency: serial edges act SYNC_STAGES+1 clk after the pin; WB read acks next clk.
// Backpressure: none; o_wb_stall is always 0, every request is acked in one cycle.
module matrix_rx
    import matrix_pkg::*;
#(
    parameter int SHIFT_BITS  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_sclk,
    input  logic        i_latch,
    input  logic        i_mosi,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [2:0]  i_wb_addr,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_wdata,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_rdata,
    output logic [7:0]  o_frame_cnt,
    output logic        o_err,
    output logic        o_err_sticky
);

    // Counter must reach SHIFT_BITS+1 so an over-long word is distinguishable.
    localparam int CNT_W = $clog2(SHIFT_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SHIFT_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SHIFT_BITS + 1);

    logic                  w_sclk_sync;
    logic                  w_sclk_rise;
    logic                  w_latch_sync;
    logic                  w_latch_rise;
    logic                  w_mosi_sync;
    logic                  w_unused_mosi_rise;
    logic                  w_unused;

    logic [SHIFT_BITS-1:0] r_shreg;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [31:0]           r_row_buf [ROWS];
    logic [7:0]            r_frame_cnt;
    logic                  r_err;
    logic                  r_err_sticky;
    logic                  r_wb_ack;
    logic [31:0]           r_wb_rdata;

    logic [3:0]            w_sel_dec;
    logic                  w_sel_valid;
    logic [2:0]            w_sel_row;
    logic                  w_accept;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  w_wb_req;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (i_sclk),
        .o_sync  (w_sclk_sync),
        .o_rise  (w_sclk_rise)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (i_latch),
        .o_sync  (w_latch_sync),
        .o_rise  (w_latch_rise)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (i_mosi),
        .o_sync  (w_mosi_sync),
        .o_rise  (w_unused_mosi_rise)
    );

    // Writes are ignored and the whole word is always returned, so these inputs
    // (and the mosi edge, which means nothing) are deliberately dropped here.
    assign w_unused = ^{i_wb_sel, i_wb_wdata, i_wb_we, w_unused_mosi_rise,
                        w_sclk_sync, w_latch_sync};

    // The latch judges the word as it stood before any same-cycle shift.
    assign w_sel_dec   = onehot_index(r_shreg[ROW_SEL_LSB +: SEL_W]);
    assign w_sel_valid = w_sel_dec[3];
    assign w_sel_row   = w_sel_dec[2:0];
    assign w_accept    = (r_bit_cnt == CNT_FULL) && w_sel_valid;
    assign w_cnt_inc   = (r_bit_cnt == CNT_SAT) ? r_bit_cnt : r_bit_cnt + CNT_W'(1);
    assign w_wb_req    = i_wb_cyc && i_wb_stb;

    // Shift register and bit counter. A shift coinciding with a latch starts
    // the next word, so the counter lands on 1 rather than 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else begin
            if (w_sclk_rise) begin
                r_shreg <= {r_shreg[SHIFT_BITS-2:0], w_mosi_sync};
            end
            if (w_sclk_rise && w_latch_rise) begin
                r_bit_cnt <= CNT_W'(1);
            end else if (w_sclk_rise) begin
                r_bit_cnt <= w_cnt_inc;
            end else if (w_latch_rise) begin
                r_bit_cnt <= '0;
            end
        end
    end

    // Accepted words overwrite their selected row; rejected words leave the buffer alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ROWS; i++) begin
                r_row_buf[i] <= '0;
            end
            r_frame_cnt <= '0;
        end else if (w_latch_rise && w_accept) begin
            r_row_buf[w_sel_row] <= pack_row(r_shreg[ROW_SEL_LSB-1:0]);
            r_frame_cnt          <= r_frame_cnt + 8'd1;
        end
    end

    // Rejection reporting: single-cycle pulse plus a flag held until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_err <= w_latch_rise && !w_accept;
            if (w_latch_rise && !w_accept) begin
                r_err_sticky <= 1'b1;
            end
        end
    end

    // Wishbone read port: ack and data one cycle after the request, data taken
    // from the buffer as it was in the request cycle. Idle cycles hold rdata.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wb_ack   <= 1'b0;
            r_wb_rdata <= '0;
        end else begin
            r_wb_ack <= w_wb_req;
            if (w_wb_req) begin
                r_wb_rdata <= r_row_buf[i_wb_addr];
            end
        end
    end

    assign o_wb_ack     = r_wb_ack;
    assign o_wb_stall   = 1'b0;
    assign o_wb_rdata   = r_wb_rdata;
    assign o_frame_cnt  = r_frame_cnt;
    assign o_err        = r_err;
    assign o_err_sticky = r_err_sticky;

endmodule

// File: tb/tb_matrix_rx.sv
// Directed bench for matrix_rx with a word-level reference model.
// Latency: serial timing slow enough for the synchronisers; WB checked at 1 cycle.
// Backpressure: none exercised; the DUT never stalls.
module tb_matrix_rx;

    localparam int HOLD = 4;

    logic        clk;
    logic        reset_n;
    logic        i_sclk;
    logic        i_latch;
    logic        i_mosi;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [2:0]  i_wb_addr;
    logic [3:0]  i_wb_sel;
    logic [31:0] i_wb_wdata;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic [31:0] o_wb_rdata;
    logic [7:0]  o_frame_cnt;
    logic        o_err;
    logic        o_err_sticky;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: bits heard since the last latch, rows, counters.
    bit          m_bits[$];
    logic [31:0] m_row [8];
    logic [7:0]  m_frame;
    logic        m_sticky;
    int          m_err_cnt;
    int          err_seen;
    bit          settled;

    matrix_rx #(.SHIFT_BITS(32), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_sclk       (i_sclk),
        .i_latch      (i_latch),
        .i_mosi       (i_mosi),
        .i_wb_cyc     (i_wb_cyc),
        .i_wb_stb     (i_wb_stb),
        .i_wb_we      (i_wb_we),
        .i_wb_addr    (i_wb_addr),
        .i_wb_sel     (i_wb_sel),
        .i_wb_wdata   (i_wb_wdata),
        .o_wb_ack     (o_wb_ack),
        .o_wb_stall   (o_wb_stall),
        .o_wb_rdata   (o_wb_rdata),
        .o_frame_cnt  (o_frame_cnt),
        .o_err        (o_err),
        .o_err_sticky (o_err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model of the bus row format: pixel p's RGB goes to byte p/2, low nibble
    // for even p and high nibble for odd p.
    function automatic logic [31:0] model_pack(input logic [23:0] pix);
        logic [31:0] row;
        int          rgb;
        row = 0;
        for (int p = 0; p < 8; p++) begin
            rgb = (pix >> (3 * p)) & 7;
            row = row | (32'(rgb) << (8 * (p / 2) + 4 * (p % 2)));
        end
        return row;
    endfunction

    function automatic void model_clear();
        m_bits.delete();
        for (int i = 0; i < 8; i++) m_row[i] = 0;
        m_frame   = 0;
        m_sticky  = 0;
        m_err_cnt = 0;
    endfunction

    // Model of a latch: exactly 32 bits with a single row bit set is stored.
    function automatic void model_latch();
        logic [31:0] w;
        logic [7:0]  sel;
        w = 0;
        foreach (m_bits[i]) w = (w << 1) | 32'(m_bits[i]);
        sel = w[31:24];
        if (m_bits.size() == 32 && sel != 0 && (sel & (sel - 8'd1)) == 0) begin
            m_row[$clog2(sel)] = model_pack(w[23:0]);
            m_frame = m_frame + 8'd1;
        end else begin
            m_sticky  = 1;
            m_err_cnt = m_err_cnt + 1;
        end
        m_bits.delete();
    endfunction

    // Continuous compare: status outputs against the model whenever no serial
    // transfer is in flight; error pulses are counted on every cycle.
    always @(negedge clk) begin
        if (!reset_n) begin
            err_seen = 0;
        end else begin
            if (o_err) err_seen = err_seen + 1;
            if (settled) begin
                check("frame_cnt", 32'(o_frame_cnt), 32'(m_frame));
                check("err_sticky", 32'(o_err_sticky), 32'(m_sticky));
                check("err_pulses", 32'(err_seen), 32'(m_err_cnt));
                check("wb_stall", 32'(o_wb_stall), 32'd0);
            end
        end
    end

    task automatic shift_bit(input bit b);
        @(negedge clk);
        i_mosi = b;
        repeat (HOLD) @(negedge clk);
        i_sclk = 1'b1;
        repeat (HOLD) @(negedge clk);
        i_sclk = 1'b0;
        m_bits.push_back(b);
    endtask

    task automatic shift_bits(input logic [31:0] w, input int n);
        settled = 0;
        for (int i = n - 1; i >= 0; i--) shift_bit(w[i]);
    endtask

    task automatic do_latch();
        settled = 0;
        @(negedge clk);
        i_latch = 1'b1;
        repeat (HOLD) @(negedge clk);
        i_latch = 1'b0;
        repeat (HOLD) @(negedge clk);
        model_latch();
        settled = 1;
    endtask

    task automatic send_word(input logic [31:0] w);
        shift_bits(w, 32);
        do_latch();
    endtask

    // Latch and the next word's first shift rise together.
    task automatic latch_with_shift(input bit b);
        settled = 0;
        @(negedge clk);
        i_mosi = b;
        repeat (HOLD) @(negedge clk);
        i_sclk  = 1'b1;
        i_latch = 1'b1;
        repeat (HOLD) @(negedge clk);
        i_sclk  = 1'b0;
        i_latch = 1'b0;
        repeat (HOLD) @(negedge clk);
        model_latch();
        m_bits.push_back(b);
        settled = 1;
    endtask

    task automatic wb_read(input logic [2:0] addr, input logic [31:0] exp, input string name);
        @(negedge clk);
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = 1'b0;
        i_wb_addr = addr;
        @(negedge clk);
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        check({name, "_ack"}, 32'(o_wb_ack), 32'd1);
        check(name, o_wb_rdata, exp);
        @(negedge clk);
        check({name, "_idle_ack"}, 32'(o_wb_ack), 32'd0);
        check({name, "_hold"}, o_wb_rdata, exp);
    endtask

    // Eight back-to-back reads, one ack per cycle.
    task automatic wb_read_all();
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("burst_ack", 32'(o_wb_ack), 32'd1);
                check($sformatf("burst_row%0d", i - 1), o_wb_rdata, m_row[i-1]);
            end
            i_wb_cyc  = (i < 8);
            i_wb_stb  = (i < 8);
            i_wb_we   = 1'b0;
            i_wb_addr = 3'(i);
        end
        @(negedge clk);
        check("burst_end_ack", 32'(o_wb_ack), 32'd0);
    endtask

    task automatic wb_write(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        i_wb_cyc   = 1'b1;
        i_wb_stb   = 1'b1;
        i_wb_we    = 1'b1;
        i_wb_sel   = 4'hF;
        i_wb_addr  = addr;
        i_wb_wdata = data;
        @(negedge clk);
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        check("write_ack", 32'(o_wb_ack), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, 32'(o_wb_ack), 32'd0);
        check({tag, "_rdata"}, o_wb_rdata, 32'd0);
        check({tag, "_frame"}, 32'(o_frame_cnt), 32'd0);
        check({tag, "_err"}, 32'(o_err), 32'd0);
        check({tag, "_sticky"}, 32'(o_err_sticky), 32'd0);
    endtask

    initial begin
        settled    = 0;
        reset_n    = 1'b0;
        i_sclk     = 1'b0;
        i_latch    = 1'b0;
        i_mosi     = 1'b0;
        i_wb_cyc   = 1'b0;
        i_wb_stb   = 1'b0;
        i_wb_we    = 1'b0;
        i_wb_addr  = '0;
        i_wb_sel   = '0;
        i_wb_wdata = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        settled = 1;
        wb_read_all();

        // All pixels white into row 0.
        send_word(32'h01FF_FFFF);
        wb_read(3'd0, 32'h7777_7777, "row0_white");
        check("frame_after_first", 32'(o_frame_cnt), 32'd1);

        // Row 7, pixel 0 = R.B.
        send_word(32'h8000_0005);
        wb_read(3'd7, 32'h0000_0005, "row7_px0");
        wb_read_all();

        // Short word rejected, then a good word into row 2.
        shift_bits(32'h0212_3456, 31);
        do_latch();
        check("short_sticky", 32'(o_err_sticky), 32'd1);
        wb_read_all();
        send_word(32'h0412_3456);
        wb_read(3'd2, 32'h0443_2126, "row2_mixed");

        // Multi-hot and empty selects both rejected.
        send_word(32'h0312_3456);
        send_word(32'h00AB_CDEF);
        check("bad_sel_frame", 32'(o_frame_cnt), 32'd3);
        check("bad_sel_pulses", 32'(err_seen), 32'd3);
        wb_read_all();

        // Latch coincides with the first bit of the following word.
        shift_bits(32'h08FE_DCBA, 32);
        latch_with_shift(1'b0);
        wb_read(3'd3, 32'h7755_6272, "row3_overlap");
        shift_bits(32'h1000_0001, 31);
        do_latch();
        wb_read(3'd4, 32'h0000_0001, "row4_after_overlap");
        wb_read_all();

        // Reset in the middle of a word.
        shift_bits(32'hAAAA_5555, 16);
        settled = 0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_clear();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        settled = 1;
        wb_read_all();
        send_word(32'h2000_0007);
        wb_read(3'd5, 32'h0000_0007, "row5_after_reset");
        check("frame_after_reset", 32'(o_frame_cnt), 32'd1);

        // Writes are acknowledged but change nothing.
        wb_write(3'd2, 32'hDEAD_BEEF);
        wb_read(3'd2, 32'h0000_0000, "row2_after_write");
        wb_write(3'd5, 32'h1234_5678);
        wb_read(3'd5, m_row[5], "row5_after_write");
        wb_read_all();

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
